// File: rtl/alu_pkg.sv
// Shared ALU function codes, the MUL detector and the scheduler FSM encoding
// used by the ALU scheduler and anything that talks to the shared ALU.
package alu_pkg;

  localparam logic [5:0] ALUFN_ADD   = 6'h00;
  localparam logic [5:0] ALUFN_SUB   = 6'h01;
  localparam logic [5:0] ALUFN_MUL   = 6'h02;
  localparam logic [5:0] ALUFN_AND   = 6'h18;
  localparam logic [5:0] ALUFN_OR    = 6'h1E;
  localparam logic [5:0] ALUFN_XOR   = 6'h16;
  localparam logic [5:0] ALUFN_A     = 6'h1A;
  localparam logic [5:0] ALUFN_SHL   = 6'h20;
  localparam logic [5:0] ALUFN_SHR   = 6'h21;
  localparam logic [5:0] ALUFN_SRA   = 6'h23;
  localparam logic [5:0] ALUFN_CMPEQ = 6'h33;
  localparam logic [5:0] ALUFN_CMPLT = 6'h35;
  localparam logic [5:0] ALUFN_CMPLE = 6'h37;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Every code of the form 6'b00xx1x is routed through the multiplier.
  function automatic logic is_mul(input logic [5:0] fn);
    return (fn[5:4] == 2'b00) && fn[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Time-shares one external combinational ALU between two requesters: grant,
// hold operands for the op latency, then return result and flags to the winner.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [5:0]  req0_alufn,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic [2:0]  rsp0_flags,
  input  logic        req1_valid,
  input  logic [5:0]  req1_alufn,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [2:0]  rsp1_flags,
  output logic [5:0]  alu_fn,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on the edge where reqX_valid && reqX_ready
  // (ready only in IDLE, combinational from the valids); a response transfers
  // on the edge where rspX_valid && rspX_ready, and is held until then.

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         fn_q, fn_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        res_q, res_d;
  logic [2:0]         flags_q, flags_d;
  logic [1:0]         gnt;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // last_q resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      fn_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      fn_q    <= fn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    fn_d    = fn_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          last_d  = gnt[1];
          fn_d    = gnt[1] ? req1_alufn : req0_alufn;
          a_d     = gnt[1] ? req1_a     : req0_a;
          b_d     = gnt[1] ? req1_b     : req0_b;
          cnt_d   = is_mul(fn_d) ? CNT_W'(MUL_CYCLES - 1) : '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          res_d   = alu_res;
          flags_d = {alu_z, alu_v, alu_n};
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    req0_ready = (state_q == ST_IDLE) && gnt[0];
    req1_ready = (state_q == ST_IDLE) && gnt[1];
    rsp0_valid = (state_q == ST_RESP) && !owner_q;
    rsp1_valid = (state_q == ST_RESP) && owner_q;
    rsp0_data  = res_q;
    rsp0_flags = flags_q;
    rsp1_data  = res_q;
    rsp1_flags = flags_q;
    alu_fn     = fn_q;
    alu_a      = a_q;
    alu_b      = b_q;
    dbg_state  = state_q;
  end

endmodule
